// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: op and size encodings,
// FSM state encoding and request decode helpers.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef struct packed {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
    } req_t;

    function automatic size_e op_size(input op_e op);
        size_e s;
        unique case (op)
            OP_LW, OP_SW:         s = SZ_W;
            OP_LH, OP_LHU, OP_SH: s = SZ_H;
            default:              s = SZ_B;
        endcase
        return s;
    endfunction

    function automatic logic op_signed(input op_e op);
        return (op == OP_LH) || (op == OP_LB);
    endfunction

    function automatic logic op_store(input op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    // The whole containing word must be addressable, not just the target lane.
    function automatic logic op_bad(
        input op_e         op,
        input logic [31:0] addr,
        input logic [31:0] num_bytes
    );
        logic mis;
        unique case (op_size(op))
            SZ_W:    mis = (addr[1:0] != 2'b00);
            SZ_H:    mis = addr[0];
            default: mis = 1'b0;
        endcase
        return mis || (({addr[31:2], 2'b00} + 32'd3) >= num_bytes);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the pipeline and the
// load/store unit.
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_op,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );

endinterface

// File: rtl/mem_lane_align.sv
// Big-endian lane extraction for loads and read-modify-write
// merge for sub-word stores.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  b;
    logic [15:0] h;

    // Byte k sits at bits [31-8k -: 8]; halfword 0 is the upper half.
    assign bsh = {~offset, 3'b000};
    assign hsh = {~offset[1], 4'b0000};
    assign b   = 8'(word >> bsh);
    assign h   = 16'(word >> hsh);

    always_comb begin
        load_val = word;
        merged   = wdata;
        unique case (1'b1)
            size == SZ_B: begin
                load_val = {{24{sign_ext & b[7]}}, b};
                merged   = (word & ~(32'h0000_00ff << bsh))
                         | ({24'b0, wdata[7:0]} << bsh);
            end
            size == SZ_H: begin
                load_val = {{16{sign_ext & h[15]}}, h};
                merged   = (word & ~(32'h0000_ffff << hsh))
                         | ({16'b0, wdata[15:0]} << hsh);
            end
            default: begin
                load_val = word;
                merged   = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one outstanding request, single read-write
// memory port, read-modify-write for sub-word stores.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int NUM_BYTES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    inout  wire  [31:0]        mem_data
);

    logic [1:0]  state;
    req_t        req_q;
    logic [31:0] word_q;
    logic [31:0] load_val;
    logic [31:0] merged;
    op_e         op_in;
    logic        bad_in;
    logic        sign_ext;
    logic        is_store;
    size_e       size;

    assign op_in    = op_e'(bus.req_op);
    assign bad_in   = op_bad(op_in, bus.req_addr, 32'(NUM_BYTES));
    assign size     = op_size(req_q.op);
    assign sign_ext = op_signed(req_q.op);
    assign is_store = op_store(req_q.op);

    mem_lane_align u_align (
        .word     (word_q),
        .offset   (req_q.addr[1:0]),
        .size     (size),
        .sign_ext (sign_ext),
        .wdata    (req_q.wdata),
        .load_val (load_val),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            req_q  <= '0;
            word_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        req_q.op    <= op_in;
                        req_q.addr  <= bus.req_addr;
                        req_q.wdata <= bus.req_wdata;
                        req_q.err   <= bad_in;
                        if (bad_in)
                            state <= ST_RESP;
                        else if (op_in == OP_SW)
                            state <= ST_WRITE;
                        else
                            state <= ST_READ;
                    end
                end
                ST_READ: begin
                    word_q <= mem_data;
                    state  <= is_store ? ST_WRITE : ST_RESP;
                end
                ST_WRITE: state <= ST_RESP;
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_err   = (state == ST_RESP) && req_q.err;

    assign bus.resp_rdata =
        ((state == ST_RESP) && !req_q.err && !is_store) ? load_val : '0;

    // Park the port on word 0 outside accesses so it is always in range.
    assign mem_we   = (state == ST_WRITE);
    assign mem_addr = ((state == ST_READ) || (state == ST_WRITE))
                    ? {req_q.addr[31:2], 2'b00} : '0;
    assign mem_data = mem_we ? merged : 'z;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural
// asynchronous-read memory on the shared data bus.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        int          id;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_addr;
    wire  [31:0] mem_data;

    mem_access_unit_if bus ();

    mem_access_unit #(.NUM_BYTES(1024)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    logic [31:0] mem [256];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    int   cyc = 0;
    int   we_cnt = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   next_id = 0;
    exp_t sb [$];
    exp_t me;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data = mem_we ? 32'bz : mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_idx] <= pre_data;
        else if (mem_we)
            mem[mem_addr[9:2]] <= mem_data;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_we) we_cnt <= we_cnt + 1;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.resp_valid) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_resp: got resp_valid=1, required 0");
            end else begin
                me = sb.pop_front();
                check($sformatf("rdata#%0d", me.id), bus.resp_rdata, me.rdata);
                check($sformatf("err#%0d", me.id), {31'b0, bus.resp_err},
                      {31'b0, me.err});
                check($sformatf("latency#%0d", me.id), cyc - me.acc, me.lat);
            end
        end
        if (mem_we)
            check("mem_addr_range", {31'b0, mem_addr < 32'd1024}, 32'd1);
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_idx  = idx;
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic issue(input op_e op, input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input logic [31:0] rdata,
                         input logic err, input int lat);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        for (int i = 0; i < 16 && !bus.req_ready; i++) @(negedge clk);
        if (!bus.req_ready) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: got req_ready=0, required 1");
            bus.req_valid = 1'b0;
            return;
        end
        e.rdata = rdata;
        e.err   = err;
        e.lat   = lat;
        e.acc   = cyc;
        e.id    = next_id;
        next_id++;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 32 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    int          w0;
    logic [31:0] m0;

    initial begin
        rst           = 1'b1;
        pre_we        = 1'b0;
        pre_idx       = '0;
        pre_data      = '0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;

        preload(8'd4, 32'h1122_3344);
        preload(8'd255, 32'hCAFE_F00D);

        // Loads back-to-back; later requests are held while busy.
        issue(OP_LW,  32'h10, 32'h0, 32'h1122_3344, 1'b0, 2);
        issue(OP_LB,  32'h13, 32'h0, 32'h0000_0044, 1'b0, 2);
        issue(OP_LH,  32'h10, 32'h0, 32'h0000_1122, 1'b0, 2);
        issue(OP_LHU, 32'h12, 32'h0, 32'h0000_3344, 1'b0, 2);
        wait_done();

        w0 = we_cnt;
        issue(OP_SB, 32'h12, 32'h0000_00AB, 32'h0, 1'b0, 3);
        wait_done();
        check("sb_word", mem[4], 32'h1122_AB44);
        check("sb_we_cycles", we_cnt - w0, 32'd1);

        w0 = we_cnt;
        issue(OP_LW, 32'h11,  32'h0, 32'h0, 1'b1, 1);
        issue(OP_SH, 32'h13,  32'h0000_5555, 32'h0, 1'b1, 1);
        issue(OP_SB, 32'h400, 32'h0000_0055, 32'h0, 1'b1, 1);
        wait_done();
        check("err_word", mem[4], 32'h1122_AB44);
        check("err_we_cycles", we_cnt - w0, 32'd0);

        issue(OP_LW, 32'h3FC, 32'h0, 32'hCAFE_F00D, 1'b0, 2);
        issue(OP_LW, 32'h3FD, 32'h0, 32'h0, 1'b1, 1);
        issue(OP_LW, 32'h400, 32'h0, 32'h0, 1'b1, 1);
        wait_done();

        issue(OP_SW, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        wait_done();
        check("sw_word", mem[8], 32'hDEAD_BEEF);
        issue(OP_SH, 32'h22, 32'hFFFF_1234, 32'h0, 1'b0, 3);
        wait_done();
        check("sh_word", mem[8], 32'hDEAD_1234);
        issue(OP_LHU, 32'h20, 32'h0, 32'h0000_DEAD, 1'b0, 2);
        issue(OP_LH,  32'h20, 32'h0, 32'hFFFF_DEAD, 1'b0, 2);
        issue(OP_LH,  32'h22, 32'h0, 32'h0000_1234, 1'b0, 2);
        wait_done();

        preload(8'd4, 32'h80FF_0000);
        issue(OP_LB,  32'h10, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
        issue(OP_LBU, 32'h10, 32'h0, 32'h0000_0080, 1'b0, 2);
        issue(OP_LH,  32'h10, 32'h0, 32'hFFFF_80FF, 1'b0, 2);
        issue(OP_LB,  32'h11, 32'h0, 32'hFFFF_FFFF, 1'b0, 2);
        wait_done();

        // Reset while the SH is in READ: dropped with no response.
        w0 = we_cnt;
        m0 = mem[4];
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SH;
        bus.req_addr  = 32'h12;
        bus.req_wdata = 32'h0000_5555;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rstmid_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid_word", mem[4], m0);
        check("rstmid_we_cycles", we_cnt - w0, 32'd0);

        issue(OP_LW, 32'h10, 32'h0, 32'h80FF_0000, 1'b0, 2);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter NUM_BYTES, default 1024, SHALL give the size in bytes of the attached memory; any access reaching a byte at or beyond it is out of range.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  1  pipeline presents a load/store request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_op  input  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-justified for SH/SB.
REQ-009 resp_valid  output  1  one-cycle completion pulse.
REQ-010 resp_rdata  output  32  load result, sign- or zero-extended; 0 for stores and errors.
REQ-011 resp_err  output  1  misaligned or out-of-range request, valid with resp_valid.
REQ-012 mem_we  output  1  write enable to the memory read-write port.
REQ-013 mem_addr  output  32  word-aligned byte address to the memory read-write port.
REQ-014 mem_data  inout  32  memory data; unit drives it only while mem_we=1, else high-Z.

Function
REQ-015 FSM states SHALL be IDLE, READ, WRITE and RESP; req_ready=1 only in IDLE.
REQ-016 In IDLE, req_valid=1 SHALL latch op, addr and wdata, and move to READ for loads/SH/SB, WRITE for SW, RESP with err=1 for bad requests.
REQ-017 Bad request: LW/SW with addr[1:0]!=0, LH/LHU/SH with addr[0]!=0, or (addr&~3)+3 >= NUM_BYTES; no memory write SHALL occur.
REQ-018 mem_addr SHALL equal latched addr&~3 in READ and WRITE, and 0 in IDLE/RESP; it must always be in range because the memory rewrites the addressed word every cycle.
REQ-019 Memory is big-endian: byte offset k occupies mem_data bits [31-8k:24-8k]; halfword offset 0 is [31:16], offset 2 is [15:0].
REQ-020 READ SHALL capture mem_data (asynchronous read) into a word register; loads go to RESP; SH/SB go to WRITE.
REQ-021 WRITE SHALL assert mem_we=1 for exactly one cycle and drive the merged word: SW = wdata; SH/SB = captured word with only the target lane replaced by wdata[15:0]/wdata[7:0]; next state RESP.
REQ-022 RESP SHALL pulse resp_valid for one cycle and return to IDLE; resp is not back-pressured.
REQ-023 Latency, acceptance to resp_valid: loads 2 cycles, SW 2, SH/SB 3, errors 1.
REQ-024 LB/LH SHALL sign-extend from bit 7/15; LBU/LHU SHALL zero-extend.
REQ-025 req_valid while req_ready=0 SHALL be ignored; the requester holds it until accepted.

Reset
REQ-026 rst=1 at a posedge SHALL force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_data high-Z.
REQ-027 rst asserted in WRITE SHALL deassert mem_we on the next edge; the write at that same edge is not guaranteed; an in-flight request is dropped with no response.

Structure
REQ-028 Op encodings and the FSM state encoding SHALL live in a shared package/include used by the decode stage.
REQ-029 Lane extraction and merge SHALL be one combinational sub-module, mem_lane_align (inputs word, offset, size, signed, wdata; outputs extended load value and merged word).

Verification
REQ-030 Memory preloaded with 0x11223344 at address 0x10; LW 0x10 -> resp_rdata=0x11223344 two cycles after acceptance, resp_err=0.
REQ-031 Same word; LB 0x13 -> 0x00000044; LH 0x10 -> 0x00001122; word 0x80FF0000 with LB 0x10 -> 0xFFFFFF80, LBU 0x10 -> 0x00000080.
REQ-032 SB 0x12 data 0xAB on 0x11223344 -> exactly one mem_we cycle, memory word becomes 0x1122AB44, response 3 cycles after acceptance.
REQ-033 LW 0x11 and SH 0x13 -> resp_err=1 after 1 cycle, mem_we never asserted, memory unchanged.
REQ-034 LW 0x3FC accepted, LW 0x3FD rejected with NUM_BYTES=1024; LW 0x400 -> resp_err=1.
REQ-035 rst asserted during the READ state of an SH -> IDLE next cycle, no resp_valid, memory unchanged, and a subsequent LW completes normally.
